// File: rtl/fetch_unit_pkg.sv
// Shared processor constants: PC-source and memory-address mux encodings,
// common to the fetch unit and the control unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_SEL_INC1 = 2'b00,
    PC_SEL_ACC  = 2'b01,
    PC_SEL_DEC3 = 2'b10,
    PC_SEL_INC2 = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    MA_SEL_IR     = 2'b00,
    MA_SEL_ACC    = 2'b01,
    MA_SEL_PC     = 2'b10,
    MA_SEL_PC_ALT = 2'b11
  } ma_sel_e;

endpackage

// File: rtl/fetch_unit_shift_register.sv
// Parallel-load register with a serial scan path: scan_in enters at the MSB,
// bits move toward the LSB, and scan_out is always the LSB.
module shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             scan_enable,
  input  logic             scan_in,
  output logic [WIDTH-1:0] data_out,
  output logic             scan_out
);

  logic [WIDTH-1:0] q;

  // Scan has priority over the functional load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (scan_enable)
      q <= {scan_in, q[WIDTH-1:1]};
    else if (load_enable)
      q <= data_in;
  end

  assign data_out = q;
  assign scan_out = q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter with next-PC mux, instruction register,
// and the memory-address mux. PC and IR form one scan chain (PC first).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              processor_enable,
  input  logic              PC_write_enable,
  input  logic [1:0]        PC_mux_select,
  input  logic              IR_load_enable,
  input  logic [1:0]        Memory_address_mux_select,
  input  logic [DATA_W-1:0] ACC,
  input  logic [DATA_W-1:0] memory_data_in,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] PC,
  input  logic              scan_enable,
  input  logic              scan_in,
  output logic              scan_out
);

  logic [ADDR_W-1:0] pc_next;
  logic              pc_load;
  logic              ir_load;
  logic              pc_scan_out;

  // Adders wrap naturally at ADDR_W bits.
  always_comb begin
    pc_next = PC + ADDR_W'(1);
    case (pc_sel_e'(PC_mux_select))
      PC_SEL_INC1: pc_next = PC + ADDR_W'(1);
      PC_SEL_ACC:  pc_next = ACC[ADDR_W-1:0];
      PC_SEL_DEC3: pc_next = PC - ADDR_W'(3);
      PC_SEL_INC2: pc_next = PC + ADDR_W'(2);
      default:     pc_next = PC + ADDR_W'(1);
    endcase
  end

  always_comb begin
    memory_address = PC;
    case (ma_sel_e'(Memory_address_mux_select))
      MA_SEL_IR:     memory_address = instruction[ADDR_W-1:0];
      MA_SEL_ACC:    memory_address = ACC[ADDR_W-1:0];
      MA_SEL_PC:     memory_address = PC;
      MA_SEL_PC_ALT: memory_address = PC;
      default:       memory_address = PC;
    endcase
  end

  assign pc_load = processor_enable & PC_write_enable;
  assign ir_load = processor_enable & IR_load_enable;

  shift_register #(.WIDTH(ADDR_W)) u_pc (
    .clk         (clk),
    .rst         (rst),
    .load_enable (pc_load),
    .data_in     (pc_next),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .data_out    (PC),
    .scan_out    (pc_scan_out)
  );

  shift_register #(.WIDTH(DATA_W)) u_ir (
    .clk         (clk),
    .rst         (rst),
    .load_enable (ir_load),
    .data_in     (memory_data_in),
    .scan_enable (scan_enable),
    .scan_in     (pc_scan_out),
    .data_out    (instruction),
    .scan_out    (scan_out)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a behavioural model
// (modular PC arithmetic, memory array, 13-bit scan chain vector).
module tb_fetch_unit;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          processor_enable;
  logic          PC_write_enable;
  logic [1:0]    PC_mux_select;
  logic          IR_load_enable;
  logic [1:0]    Memory_address_mux_select;
  logic [DW-1:0] ACC;
  logic [DW-1:0] memory_data_in;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] instruction;
  logic [AW-1:0] PC;
  logic          scan_enable;
  logic          scan_in;
  logic          scan_out;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .processor_enable          (processor_enable),
    .PC_write_enable           (PC_write_enable),
    .PC_mux_select             (PC_mux_select),
    .IR_load_enable            (IR_load_enable),
    .Memory_address_mux_select (Memory_address_mux_select),
    .ACC                       (ACC),
    .memory_data_in            (memory_data_in),
    .memory_address            (memory_address),
    .instruction               (instruction),
    .PC                        (PC),
    .scan_enable               (scan_enable),
    .scan_in                   (scan_in),
    .scan_out                  (scan_out)
  );

  logic [DW-1:0] mem [MEMSZ];
  assign memory_data_in = mem[memory_address];

  int n_cmp = 0;
  int n_err = 0;

  int            m_pc;
  logic [DW-1:0] m_ir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_addr();
    case (Memory_address_mux_select)
      2'd0:    return int'(m_ir) % MEMSZ;
      2'd1:    return int'(ACC) % MEMSZ;
      default: return m_pc;
    endcase
  endfunction

  function automatic int exp_next_pc();
    case (PC_mux_select)
      2'd0:    return (m_pc + 1) % MEMSZ;
      2'd1:    return int'(ACC) % MEMSZ;
      2'd2:    return (m_pc + MEMSZ - 3) % MEMSZ;
      default: return (m_pc + 2) % MEMSZ;
    endcase
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_pc"}, 32'(PC), 32'(m_pc));
    chk({tag, "_ir"}, 32'(instruction), 32'(m_ir));
    chk({tag, "_so"}, 32'(scan_out), 32'(m_ir[0]));
  endtask

  // One clock with the currently driven inputs; model updated from pre-edge values.
  task automatic step(input string tag);
    int             na;
    int             np;
    logic [DW-1:0]  nd;
    logic [AW+DW-1:0] ch;
    #1;
    na = exp_addr();
    chk({tag, "_addr"}, 32'(memory_address), 32'(na));
    np = exp_next_pc();
    nd = mem[na];
    @(posedge clk);
    if (scan_enable) begin
      ch = {AW'(m_pc), m_ir};
      ch = {scan_in, ch[AW+DW-1:1]};
      m_pc = int'(ch[AW+DW-1:DW]);
      m_ir = ch[DW-1:0];
    end else if (processor_enable) begin
      if (PC_write_enable) m_pc = np;
      if (IR_load_enable) m_ir = nd;
    end
    #1;
    chk_state(tag);
  endtask

  task automatic set_in(input logic pe, input logic pw, input logic [1:0] ps,
                        input logic il, input logic [1:0] ms, input logic [DW-1:0] acc);
    processor_enable = pe;
    PC_write_enable = pw;
    PC_mux_select = ps;
    IR_load_enable = il;
    Memory_address_mux_select = ms;
    ACC = acc;
    scan_enable = 1'b0;
    scan_in = 1'b0;
  endtask

  logic [AW+DW-1:0] pat;
  logic [AW-1:0]    hold_pc;
  logic [DW-1:0]    hold_ir;

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = DW'($urandom);
    rst = 1'b1;
    set_in(1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 8'h00);
    m_pc = 0;
    m_ir = '0;
    #1;
    chk_state("reset");
    #11;
    rst = 1'b0;

    // Three fetches from addresses 0..2
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    for (int i = 0; i < 3; i++) step("fetch");
    chk("fetch3_ir", 32'(instruction), 32'h33);
    chk("fetch3_pc", 32'(PC), 32'd3);

    // PC wrap-around cases
    set_in(1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 8'd31); step("ld31");
    set_in(1'b1, 1'b1, 2'd0, 1'b0, 2'd2, 8'd0);  step("wrap_inc1");
    chk("wrap_inc1_c", 32'(PC), 32'd0);
    set_in(1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 8'd1);  step("ld1");
    set_in(1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 8'd0);  step("wrap_dec3");
    chk("wrap_dec3_c", 32'(PC), 32'd30);
    set_in(1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 8'd2);  step("ld2");
    set_in(1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 8'd0);  step("wrap_dec3b");
    chk("wrap_dec3b_c", 32'(PC), 32'd31);
    set_in(1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 8'd30); step("ld30");
    set_in(1'b1, 1'b1, 2'd3, 1'b0, 2'd2, 8'd0);  step("wrap_inc2");
    chk("wrap_inc2_c", 32'(PC), 32'd0);

    // Jump via ACC, upper bits ignored; LDAR address same cycle
    set_in(1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 8'hE7);
    #1;
    chk("ldar_addr", 32'(memory_address), 32'd7);
    step("jump");
    chk("jump_pc", 32'(PC), 32'd7);

    // Disabled processor holds state
    hold_pc = PC;
    hold_ir = instruction;
    set_in(1'b0, 1'b1, 2'd3, 1'b1, 2'd2, 8'h5A);
    for (int i = 0; i < 5; i++) step("hold");
    chk("hold_pc_c", 32'(PC), 32'(hold_pc));
    chk("hold_ir_c", 32'(instruction), 32'(hold_ir));

    // Scan in a 13-bit pattern, then shift it back out
    pat = 13'b1010011001101;
    set_in(1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 8'h00);
    scan_enable = 1'b1;
    for (int i = 0; i < AW + DW; i++) begin
      scan_in = pat[i];
      step("scan_in");
    end
    chk("scan_img", 32'({PC, instruction}), 32'(pat));
    scan_in = 1'b0;
    for (int i = 0; i < AW + DW; i++) begin
      #1;
      chk("scan_out_bit", 32'(scan_out), 32'(pat[i]));
      step("scan_out");
    end

    // Asynchronous reset mid-scan with PC=9
    set_in(1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 8'd9);
    step("ld9");
    chk("ld9_c", 32'(PC), 32'd9);
    scan_enable = 1'b1;
    scan_in = 1'b1;
    step("scan_pre_rst");
    #2;
    rst = 1'b1;
    #1;
    m_pc = 0;
    m_ir = '0;
    chk_state("async_rst");
    rst = 1'b0;
    set_in(1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 8'h00);
    step("post_rst_fetch");
    chk("post_rst_pc", 32'(PC), 32'd1);

    // Randomized traffic
    for (int i = 0; i < MEMSZ; i++) mem[i] = DW'($urandom);
    for (int n = 0; n < 300; n++) begin
      set_in(($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom),
             1'($urandom), 2'($urandom), DW'($urandom));
      scan_enable = ($urandom_range(0, 9) == 0);
      scan_in = 1'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory/PC address width (32-byte memory).
REQ-002 SHALL have parameter DATA_W, default 8, instruction/ACC/memory data width.
REQ-003 SHALL have port clk  input  1  sole clock; all registers update on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port processor_enable  input  1  gates PC/IR updates.
REQ-006 SHALL have port PC_write_enable  input  1  load PC from PC mux.
REQ-007 SHALL have port PC_mux_select  input  2  00 PC+1, 01 ACC[ADDR_W-1:0], 10 PC-3, 11 PC+2.
REQ-008 SHALL have port IR_load_enable  input  1  load IR from memory_data_in.
REQ-009 SHALL have port Memory_address_mux_select  input  2  00 IR[ADDR_W-1:0], 01 ACC[ADDR_W-1:0], 10 PC, 11 PC.
REQ-010 SHALL have port ACC  input  DATA_W  accumulator value (jump target, LDAR address).
REQ-011 SHALL have port memory_data_in  input  DATA_W  memory read data at memory_address.
REQ-012 SHALL have port memory_address  output  ADDR_W  combinational memory address.
REQ-013 SHALL have port instruction  output  DATA_W  IR contents, to control unit and ALU immediate.
REQ-014 SHALL have port PC  output  ADDR_W  PC contents (JSR return value to ACC mux).
REQ-015 SHALL have ports scan_enable input 1, scan_in input 1, scan_out output 1  scan chain.

Function
REQ-016 PC SHALL load the selected mux value on a rising edge when processor_enable=1, PC_write_enable=1, scan_enable=0; otherwise hold.
REQ-017 PC arithmetic SHALL be modulo 2^ADDR_W: PC=31 +1 -> 0; PC=30 +2 -> 0; PC=1 -3 -> 30; PC=2 -3 -> 31.
REQ-018 PC_mux_select=01 SHALL use ACC low ADDR_W bits; upper ACC bits ignored.
REQ-019 IR SHALL load memory_data_in on a rising edge when processor_enable=1, IR_load_enable=1, scan_enable=0; otherwise hold.
REQ-020 Simultaneous PC write and IR load (FETCH) SHALL load IR with data addressed by the pre-edge PC and PC with pre-edge PC+1, same edge.
REQ-021 memory_address SHALL be purely combinational from Memory_address_mux_select, IR, ACC, PC; zero-cycle latency.
REQ-022 instruction and PC outputs SHALL be direct register outputs, no combinational path from inputs.
REQ-023 With scan_enable=1, PC and IR SHALL shift one bit per clock regardless of processor_enable and load enables; functional loads suppressed.
REQ-024 Scan order SHALL be scan_in -> PC[ADDR_W-1] ... PC[0] -> IR[DATA_W-1] ... IR[0] -> scan_out; chain length ADDR_W+DATA_W (13).
REQ-025 scan_out SHALL equal IR[0] at all times.
REQ-026 With processor_enable=0 and scan_enable=0, all state SHALL hold indefinitely.

Reset
REQ-027 rst=1 SHALL asynchronously clear PC to 0 and IR to 0 (instruction=8'h00), overriding scan and functional loads.
REQ-028 After rst deasserts, first enabled FETCH edge SHALL load IR from address 0 and set PC=1.
REQ-029 Reset asserted mid-scan SHALL discard partial scan contents; state is 0 on release.

Structure
REQ-030 PC mux encodings and memory-address mux encodings SHALL be constants in the shared processor package, shared with the control unit.
REQ-031 PC and IR SHALL each be an instance of the existing shift_register sub-module (WIDTH=ADDR_W, WIDTH=DATA_W), chained via scan_out->scan_in.
REQ-032 PC mux, adders and address mux SHALL be local combinational logic in fetch_unit.

Verification
REQ-033 Reset, then 3 edges with PC_write_enable=1, sel=00, IR_load_enable=1, mem[0..2]=8'h11,8'h22,8'h33 -> IR=8'h33, PC=3.
REQ-034 PC=31, sel=00 write -> PC=0; PC=1, sel=10 -> PC=30; PC=30, sel=11 -> PC=0.
REQ-035 ACC=8'hE7, sel=01 write -> PC=5'd7; Memory_address_mux_select=01 -> memory_address=7 same cycle.
REQ-036 scan_enable=1, shift 13 bits 1010011001101 -> PC/IR hold pattern per REQ-024; 13 further shifts reproduce it on scan_out.
REQ-037 processor_enable=0 with all enables high for 5 edges -> PC and IR unchanged.
REQ-038 Assert rst between clock edges during scan with PC=9 -> PC=0, IR=0 immediately, before next edge.
